scroll_sequencer: RTL and testbench
===================================

Name: scroll_sequencer

Overview:
Controller that sequences a 4-digit hex display window across a 32-bit word at nibble granularity. It debounces two pushbuttons, runs a manual/auto/pause state machine, and produces the window position and the 16-bit display word. Its output drives the existing 16-bit hex display driver directly. It replaces the single-bit half-select scroll path with 5 window positions.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable synchronized samples required to accept a button level change
AUTO_PERIOD, 50000000, clk cycles between automatic scroll steps (minimum 2)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
value  input  32  word to scroll; captured on load
load  input  1  one-cycle strobe: capture value, restart window at position 0
btn_step  input  1  raw pushbutton: step (manual) / pause-resume (auto)
btn_mode  input  1  raw pushbutton: toggle manual/auto
scroll_pos  output  3  current window position, 0..4
disp_word  output  16  registered window contents for the display driver
auto_mode  output  1  high in AUTO_RUN or AUTO_PAUSE
paused  output  1  high in AUTO_PAUSE only

Behaviour:
- Reset (rst=1 at a clock edge): state=MANUAL; scroll_pos=0; value_reg=0; disp_word=16'h0000; auto_mode=0; paused=0; tick counter=0; debouncers cleared (debounced level 0, counters 0, sync flops 0). Reset mid-operation aborts everything, including a pending tick.
- Button path, per button: 2-flop synchronizer; counter increments while the synchronized sample differs from the debounced level and clears when it matches; at DEBOUNCE_CYCLES the debounced level flips and the counter clears. A rising edge of the debounced level gives a 1-cycle pulse (step_p / mode_p). Falling edges give no pulse. Total press-to-pulse latency = 2 + DEBOUNCE_CYCLES + 1 cycles.
- Window: disp_word = value_reg[31-4*pos -: 16]. pos0=[31:16], pos1=[27:12], pos2=[23:8], pos3=[19:4], pos4=[15:0]. disp_word is registered: it updates 1 cycle after scroll_pos or value_reg changes.
- load: value_reg<=value, scroll_pos<=0, tick counter<=0 in the same edge. The state is unchanged. If load coincides with step_p or a tick, load wins and the step/tick is dropped.
- FSM:
  - MANUAL: step_p advances pos; mode_p -> AUTO_RUN (tick counter cleared).
  - AUTO_RUN: tick counter counts 0..AUTO_PERIOD-1. At terminal count it advances pos and wraps to 0. step_p -> AUTO_PAUSE. mode_p -> MANUAL.
  - AUTO_PAUSE: counter frozen and pos held; step_p -> AUTO_RUN (counter resumes from its frozen value); mode_p -> MANUAL.
  - If step_p and mode_p arrive in the same cycle, mode_p wins and step_p is ignored.
  - If a tick and mode_p arrive in the same cycle in AUTO_RUN, the tick's advance is applied and the state goes to MANUAL.
- Advance (default, wrap): pos 0->1->2->3->4->0.
- scroll_pos is never outside 0..4.

Optional Feature:
SCROLL_BOUNCE_EN
- Defined: a 1-bit direction register (reset = forward) gives ping-pong motion 0..4..0: 3->4, 4->3 (direction flips at 4), 1->0, 0->1 (direction flips at 0). load also resets the direction to forward.
- Undefined: the direction register is absent and the wrap sequence above applies.

Test Plan:
- Bench settings: DEBOUNCE_CYCLES=4, AUTO_PERIOD=8, value=32'h24E2C17D.
- Reset then load -> scroll_pos=0; next cycle disp_word=16'h24E2; auto_mode=0.
- MANUAL, five clean btn_step presses -> disp_word sequence 4E2C, E2C1, 2C17, C17D, 24E2. Each pulse arrives exactly 7 cycles after the press. A 3-cycle glitch press gives no step.
- btn_mode press -> auto_mode=1; pos advances every 8 cycles. A btn_step press -> paused=1 and pos frozen for 40 cycles. A second press resumes, and the first advance comes after the remaining count.
- Same-cycle step_p and mode_p (both buttons pressed together) in MANUAL -> state AUTO_RUN, pos unchanged. Same-cycle load and tick at pos3 -> pos=0, disp_word=new value[31:16].
- Assert rst while in AUTO_RUN at pos2 with the counter at 5 -> next cycle: MANUAL, pos0, disp_word 0000, counters 0.
- With SCROLL_BOUNCE_EN, AUTO_RUN for 80 cycles -> pos sequence 1,2,3,4,3,2,1,0,1,2. Without it -> 1,2,3,4,0,1,2,3,4,0.

Source files
------------

// File: rtl/scroll_sequencer.sv
// Nibble-granular 4-digit display window over a 32-bit word with debounced step/mode buttons.
// Define SCROLL_BOUNCE_EN for ping-pong window motion instead of wrap-around.

module scroll_debounce #(
  parameter int unsigned CYCLES = 500000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic pulse_o
);
  localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          level_dly_q;
  logic          pulse_q;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(CYCLES - 1)) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      pulse_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= btn_i;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      // registered rising-edge detect adds the final cycle of press-to-pulse latency
      pulse_q     <= level_q & ~level_dly_q;
      cnt_q       <= cnt_d;
    end
  end

  assign pulse_o = pulse_q;
endmodule

module scroll_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned AUTO_PERIOD     = 50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value,
  input  logic        load,
  input  logic        btn_step,
  input  logic        btn_mode,
  output logic [2:0]  scroll_pos,
  output logic [15:0] disp_word,
  output logic        auto_mode,
  output logic        paused
);
  localparam int unsigned TW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;

  typedef enum logic [1:0] {
    ST_MANUAL,
    ST_AUTO_RUN,
    ST_AUTO_PAUSE
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    pos_q, pos_d;
  logic [31:0]   value_q, value_d;
  logic [15:0]   disp_q, disp_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    adv_pos;
  logic          advance;
  logic          tick;
  logic          step_p, mode_p;
`ifdef SCROLL_BOUNCE_EN
  logic          dir_q, dir_d;
  logic          adv_dir;
`endif

  scroll_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_step (
    .clk_i   (clk),
    .rst_i   (rst),
    .btn_i   (btn_step),
    .pulse_o (step_p)
  );

  scroll_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk_i   (clk),
    .rst_i   (rst),
    .btn_i   (btn_mode),
    .pulse_o (mode_p)
  );

  // Next window position for one advance step
  always_comb begin
    adv_pos = 3'd0;
`ifdef SCROLL_BOUNCE_EN
    adv_dir = dir_q;
    if (!dir_q) begin
      if (pos_q >= 3'd4) begin
        adv_pos = 3'd3;
        adv_dir = 1'b1;
      end else begin
        adv_pos = pos_q + 3'd1;
      end
    end else begin
      if (pos_q == 3'd0) begin
        adv_pos = 3'd1;
        adv_dir = 1'b0;
      end else begin
        adv_pos = pos_q - 3'd1;
      end
    end
`else
    adv_pos = (pos_q >= 3'd4) ? 3'd0 : pos_q + 3'd1;
`endif
  end

  assign tick = (state_q == ST_AUTO_RUN) && (tick_q == TW'(AUTO_PERIOD - 1));

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    value_d = value_q;
    tick_d  = tick_q;
    advance = 1'b0;
`ifdef SCROLL_BOUNCE_EN
    dir_d   = dir_q;
`endif
    unique case (state_q)
      ST_MANUAL: begin
        if (mode_p) begin
          state_d = ST_AUTO_RUN;
          tick_d  = '0;
        end else if (step_p && !load) begin
          advance = 1'b1;
        end
      end
      ST_AUTO_RUN: begin
        if (tick) begin
          advance = 1'b1;
          tick_d  = '0;
        end else begin
          tick_d = tick_q + 1'b1;
        end
        if (mode_p) begin
          state_d = ST_MANUAL;
        end else if (step_p && !load) begin
          state_d = ST_AUTO_PAUSE;
        end
      end
      ST_AUTO_PAUSE: begin
        if (mode_p) begin
          state_d = ST_MANUAL;
        end else if (step_p && !load) begin
          state_d = ST_AUTO_RUN;
        end
      end
      default: state_d = ST_MANUAL;
    endcase

    if (advance) begin
      pos_d = adv_pos;
`ifdef SCROLL_BOUNCE_EN
      dir_d = adv_dir;
`endif
    end

    // load overrides any step/tick position update in the same cycle
    if (load) begin
      value_d = value;
      pos_d   = 3'd0;
      tick_d  = '0;
`ifdef SCROLL_BOUNCE_EN
      dir_d   = 1'b0;
`endif
    end
  end

  always_comb begin
    disp_d = value_q[31:16];
    case (pos_q)
      3'd0:    disp_d = value_q[31:16];
      3'd1:    disp_d = value_q[27:12];
      3'd2:    disp_d = value_q[23:8];
      3'd3:    disp_d = value_q[19:4];
      3'd4:    disp_d = value_q[15:0];
      default: disp_d = value_q[31:16];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_MANUAL;
      pos_q   <= 3'd0;
      value_q <= '0;
      disp_q  <= '0;
      tick_q  <= '0;
`ifdef SCROLL_BOUNCE_EN
      dir_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      value_q <= value_d;
      disp_q  <= disp_d;
      tick_q  <= tick_d;
`ifdef SCROLL_BOUNCE_EN
      dir_q   <= dir_d;
`endif
    end
  end

  assign scroll_pos = pos_q;
  assign disp_word  = disp_q;
  assign auto_mode  = (state_q == ST_AUTO_RUN) || (state_q == ST_AUTO_PAUSE);
  assign paused     = (state_q == ST_AUTO_PAUSE);
endmodule

// File: tb/tb_scroll_sequencer.sv
// Directed self-checking bench for scroll_sequencer (DEBOUNCE_CYCLES=4, AUTO_PERIOD=8).
// Expected positions follow SCROLL_BOUNCE_EN when it is defined.

module tb_scroll_sequencer;
  logic        clk;
  logic        rst;
  logic [31:0] value;
  logic        load;
  logic        btn_step;
  logic        btn_mode;
  logic [2:0]  scroll_pos;
  logic [15:0] disp_word;
  logic        auto_mode;
  logic        paused;

  int n_checks;
  int n_fail;

  localparam logic [31:0] V1 = 32'h24E2C17D;
  localparam logic [31:0] V2 = 32'hA5F09B36;

  scroll_sequencer #(
    .DEBOUNCE_CYCLES (4),
    .AUTO_PERIOD     (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .load       (load),
    .btn_step   (btn_step),
    .btn_mode   (btn_mode),
    .scroll_pos (scroll_pos),
    .disp_word  (disp_word),
    .auto_mode  (auto_mode),
    .paused     (paused)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    n_checks++; if (scroll_pos !== 3'd0) begin n_fail++; $display("FAIL reset_pos: got %0d expected 0", scroll_pos); end
    n_checks++; if (disp_word !== 16'h0000) begin n_fail++; $display("FAIL reset_disp: got %h expected 0000", disp_word); end
    n_checks++; if (auto_mode !== 1'b0) begin n_fail++; $display("FAIL reset_auto: got %b expected 0", auto_mode); end
    n_checks++; if (paused !== 1'b0) begin n_fail++; $display("FAIL reset_paused: got %b expected 0", paused); end
  endtask

  task automatic test_load();
    value = V1;
    load  = 1'b1;
    cyc(1);
    load  = 1'b0;
    n_checks++; if (scroll_pos !== 3'd0) begin n_fail++; $display("FAIL load_pos: got %0d expected 0", scroll_pos); end
    cyc(1);
    n_checks++; if (disp_word !== 16'h24E2) begin n_fail++; $display("FAIL load_disp: got %h expected 24e2", disp_word); end
    n_checks++; if (auto_mode !== 1'b0) begin n_fail++; $display("FAIL load_auto: got %b expected 0", auto_mode); end
  endtask

  task automatic test_manual();
    logic [15:0] exp_disp [5];
    logic [2:0]  exp_pos  [5];
    exp_disp = '{16'h4E2C, 16'hE2C1, 16'h2C17, 16'hC17D, 16'h24E2};
    exp_pos  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    for (int i = 0; i < 5; i++) begin
      btn_step = 1'b1;
      cyc(7);
      n_checks++; if (scroll_pos !== ((i == 0) ? 3'd0 : exp_pos[i-1])) begin n_fail++; $display("FAIL manual_early[%0d]: got %0d expected %0d", i, scroll_pos, (i == 0) ? 3'd0 : exp_pos[i-1]); end
      cyc(1);
      n_checks++; if (scroll_pos !== exp_pos[i]) begin n_fail++; $display("FAIL manual_pos[%0d]: got %0d expected %0d", i, scroll_pos, exp_pos[i]); end
      cyc(1);
      n_checks++; if (disp_word !== exp_disp[i]) begin n_fail++; $display("FAIL manual_disp[%0d]: got %h expected %h", i, disp_word, exp_disp[i]); end
      btn_step = 1'b0;
      cyc(10);
    end
    btn_step = 1'b1;
    cyc(3);
    btn_step = 1'b0;
    cyc(12);
    n_checks++; if (scroll_pos !== 3'd0) begin n_fail++; $display("FAIL glitch_pos: got %0d expected 0", scroll_pos); end
  endtask

  task automatic test_auto();
    btn_mode = 1'b1;
    cyc(8);
    btn_mode = 1'b0;
    n_checks++; if (auto_mode !== 1'b1) begin n_fail++; $display("FAIL auto_enter: got %b expected 1", auto_mode); end
    n_checks++; if (scroll_pos !== 3'd0) begin n_fail++; $display("FAIL auto_pos0: got %0d expected 0", scroll_pos); end
    cyc(7);
    n_checks++; if (scroll_pos !== 3'd0) begin n_fail++; $display("FAIL auto_pre_tick: got %0d expected 0", scroll_pos); end
    cyc(1);
    n_checks++; if (scroll_pos !== 3'd1) begin n_fail++; $display("FAIL auto_tick1: got %0d expected 1", scroll_pos); end
    cyc(2);
    btn_step = 1'b1;
    cyc(7);
    n_checks++; if (paused !== 1'b0) begin n_fail++; $display("FAIL pause_early: got %b expected 0", paused); end
    n_checks++; if (scroll_pos !== 3'd2) begin n_fail++; $display("FAIL auto_tick2: got %0d expected 2", scroll_pos); end
    cyc(1);
    n_checks++; if (paused !== 1'b1) begin n_fail++; $display("FAIL pause_enter: got %b expected 1", paused); end
    btn_step = 1'b0;
    cyc(40);
    n_checks++; if (scroll_pos !== 3'd2) begin n_fail++; $display("FAIL pause_hold_pos: got %0d expected 2", scroll_pos); end
    n_checks++; if (paused !== 1'b1) begin n_fail++; $display("FAIL pause_hold: got %b expected 1", paused); end
    n_checks++; if (auto_mode !== 1'b1) begin n_fail++; $display("FAIL pause_auto: got %b expected 1", auto_mode); end
    btn_step = 1'b1;
    cyc(8);
    btn_step = 1'b0;
    n_checks++; if (paused !== 1'b0) begin n_fail++; $display("FAIL resume: got %b expected 0", paused); end
    n_checks++; if (scroll_pos !== 3'd2) begin n_fail++; $display("FAIL resume_pos: got %0d expected 2", scroll_pos); end
    cyc(5);
    n_checks++; if (scroll_pos !== 3'd2) begin n_fail++; $display("FAIL resume_pre_tick: got %0d expected 2", scroll_pos); end
    cyc(1);
    n_checks++; if (scroll_pos !== 3'd3) begin n_fail++; $display("FAIL resume_tick: got %0d expected 3", scroll_pos); end
    // mode pulse lands on the same edge as the next tick
    btn_mode = 1'b1;
    cyc(7);
    n_checks++; if (scroll_pos !== 3'd3 || auto_mode !== 1'b1) begin n_fail++; $display("FAIL tick_mode_pre: got pos %0d auto %b expected pos 3 auto 1", scroll_pos, auto_mode); end
    cyc(1);
    n_checks++; if (scroll_pos !== 3'd4) begin n_fail++; $display("FAIL tick_mode_pos: got %0d expected 4", scroll_pos); end
    n_checks++; if (auto_mode !== 1'b0) begin n_fail++; $display("FAIL tick_mode_state: got %b expected 0", auto_mode); end
    btn_mode = 1'b0;
    cyc(10);
  endtask

  task automatic test_both_buttons();
    btn_step = 1'b1;
    btn_mode = 1'b1;
    cyc(8);
    btn_step = 1'b0;
    btn_mode = 1'b0;
    n_checks++; if (auto_mode !== 1'b1 || paused !== 1'b0) begin n_fail++; $display("FAIL both_state: got auto %b paused %b expected auto 1 paused 0", auto_mode, paused); end
    n_checks++; if (scroll_pos !== 3'd4) begin n_fail++; $display("FAIL both_pos: got %0d expected 4", scroll_pos); end
    cyc(2);
  endtask

  task automatic test_load_tick_and_reset();
    value = V1;
    load  = 1'b1;
    cyc(1);
    load  = 1'b0;
    n_checks++; if (scroll_pos !== 3'd0) begin n_fail++; $display("FAIL auto_load_pos: got %0d expected 0", scroll_pos); end
    cyc(30);
    n_checks++; if (scroll_pos !== 3'd3) begin n_fail++; $display("FAIL load_tick_pre: got %0d expected 3", scroll_pos); end
    value = V2;
    load  = 1'b1;
    cyc(1);
    load  = 1'b0;
    n_checks++; if (scroll_pos !== 3'd0) begin n_fail++; $display("FAIL load_tick_pos: got %0d expected 0", scroll_pos); end
    cyc(1);
    n_checks++; if (disp_word !== 16'hA5F0) begin n_fail++; $display("FAIL load_tick_disp: got %h expected a5f0", disp_word); end
    cyc(20);
    n_checks++; if (scroll_pos !== 3'd2 || auto_mode !== 1'b1) begin n_fail++; $display("FAIL pre_rst: got pos %0d auto %b expected pos 2 auto 1", scroll_pos, auto_mode); end
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    n_checks++; if (auto_mode !== 1'b0 || paused !== 1'b0) begin n_fail++; $display("FAIL mid_rst_state: got auto %b paused %b expected 0 0", auto_mode, paused); end
    n_checks++; if (scroll_pos !== 3'd0) begin n_fail++; $display("FAIL mid_rst_pos: got %0d expected 0", scroll_pos); end
    n_checks++; if (disp_word !== 16'h0000) begin n_fail++; $display("FAIL mid_rst_disp: got %h expected 0000", disp_word); end
  endtask

  task automatic test_sweep();
    logic [2:0] exp_seq [10];
`ifdef SCROLL_BOUNCE_EN
    exp_seq = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1, 3'd2};
`else
    exp_seq = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
`endif
    value = V1;
    load  = 1'b1;
    cyc(1);
    load  = 1'b0;
    btn_mode = 1'b1;
    cyc(8);
    btn_mode = 1'b0;
    n_checks++; if (auto_mode !== 1'b1) begin n_fail++; $display("FAIL sweep_enter: got %b expected 1", auto_mode); end
    for (int i = 0; i < 10; i++) begin
      cyc(8);
      n_checks++; if (scroll_pos !== exp_seq[i]) begin n_fail++; $display("FAIL sweep_pos[%0d]: got %0d expected %0d", i, scroll_pos, exp_seq[i]); end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    value    = '0;
    load     = 1'b0;
    btn_step = 1'b0;
    btn_mode = 1'b0;
    test_reset();
    test_load();
    test_manual();
    test_auto();
    test_both_buttons();
    test_load_tick_and_reset();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
